// File: rtl/rand_stream_pkg.sv
// Shared types and LFSR constants for the randomised-gap stream master.
package rand_stream_pkg;

    localparam int unsigned LfsrWidth = 16;
    localparam logic [LfsrWidth-1:0] LfsrTaps = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_e;

    // One right-shifting Galois step.
    function automatic logic [LfsrWidth-1:0] lfsr_step(input logic [LfsrWidth-1:0] l);
        return (l >> 1) ^ (l[0] ? LfsrTaps : '0);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Minimal fifo_v3-compatible circular buffer (registered head, pointers wrap modulo DEPTH).
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned CntW = ADDR_DEPTH + 1;

    if (FALL_THROUGH) begin : g_no_fall_through
        $fatal(1, "fifo_v3: fall-through mode is not provided by this implementation");
    end

    dtype                  mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_q;
    logic [ADDR_DEPTH-1:0] wr_q;
    logic [CntW-1:0]       cnt_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= (wr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (pop_ok)  rd_q <= (rd_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    // Storage needs no reset: the counters alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/rand_stream_mst.sv
// Stream master: buffers pushed beats and emits them in order with LFSR-drawn idle gaps.
module rand_stream_mst
    import rand_stream_pkg::*;
#(
    parameter type                  data_t        = logic,
    parameter int                   Depth         = 4,
    parameter int                   MinWaitCycles = 0,
    parameter int                   MaxWaitCycles = 0,
    parameter logic [LfsrWidth-1:0] LfsrSeed      = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  data_t                        push_data_i,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    output data_t                        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         idle_o
);
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned WaitW = (MaxWaitCycles > 0) ? $clog2(MaxWaitCycles + 1) : 1;
    localparam int unsigned Range = unsigned'(MaxWaitCycles - MinWaitCycles + 1);

    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "rand_stream_mst: Depth must be >= 2");
    end
    if (MinWaitCycles < 0) begin : g_bad_min
        $fatal(1, "rand_stream_mst: MinWaitCycles must be >= 0");
    end
    if (MaxWaitCycles < MinWaitCycles) begin : g_bad_max
        $fatal(1, "rand_stream_mst: MaxWaitCycles must be >= MinWaitCycles");
    end
    if (LfsrSeed == '0) begin : g_bad_seed
        $fatal(1, "rand_stream_mst: LfsrSeed must be nonzero");
    end

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
    logic                 valid_q;
    logic [WaitW-1:0]     wait_draw;
    logic                 draw;
    logic                 pop;
    logic                 push_acc;
    logic                 full;
    logic                 empty;
    logic [AddrW-1:0]     usage;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (Depth),
        .dtype        (data_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (1'b0),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage),
        .data_i  (push_data_i),
        .push_i  (push_valid_i),
        .data_o  (data_o),
        .pop_i   (pop)
    );

    assign push_ready_o = !full;
    assign push_acc     = push_valid_i && !full;
    assign count_o      = full ? CntW'(Depth) : CntW'(usage);
    assign valid_o      = valid_q;
    assign idle_o       = empty && !valid_q;
    assign wait_draw    = WaitW'(MinWaitCycles) + WaitW'(lfsr_q % LfsrWidth'(Range));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            lfsr_q  <= LfsrSeed;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lfsr_q  <= lfsr_d;
            valid_q <= (state_d == VALID);
        end
    end

    // A draw happens when a new beat becomes eligible; W=0 skips WAIT entirely.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lfsr_d  = lfsr_q;
        draw    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) draw = 1'b1;
            end
            WAIT: begin
                if (wait_q <= WaitW'(1)) begin
                    state_d = VALID;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            VALID: begin
                if (ready_i) begin
                    pop = 1'b1;
                    if ((count_o > CntW'(1)) || push_acc) draw = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (draw) begin
            lfsr_d = lfsr_step(lfsr_q);
            if (wait_draw == '0) begin
                state_d = VALID;
                wait_d  = '0;
            end else begin
                state_d = WAIT;
                wait_d  = wait_draw;
            end
        end
    end

endmodule

// File: tb/tb_rand_stream_mst.sv
// Bench for rand_stream_mst: three configurations, scoreboard-checked ordering and gap timing.
module tb_rand_stream_mst;

    logic clk;
    logic rst;

    logic [7:0] a_push_data, a_data;
    logic       a_push_valid, a_push_ready, a_valid, a_ready, a_idle;
    logic [2:0] a_count;
    logic [7:0] b_push_data, b_data;
    logic       b_push_valid, b_push_ready, b_valid, b_ready, b_idle;
    logic [2:0] b_count;
    logic [7:0] c_push_data, c_data;
    logic       c_push_valid, c_push_ready, c_valid, c_ready, c_idle;
    logic [2:0] c_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0] qa[$];
    logic [7:0] qc[$];

    rand_stream_mst #(.data_t(logic [7:0]), .Depth(4), .MinWaitCycles(0), .MaxWaitCycles(0)) u_a (
        .clk_i(clk), .rst_i(rst), .push_data_i(a_push_data), .push_valid_i(a_push_valid),
        .push_ready_o(a_push_ready), .data_o(a_data), .valid_o(a_valid), .ready_i(a_ready),
        .count_o(a_count), .idle_o(a_idle));

    rand_stream_mst #(.data_t(logic [7:0]), .Depth(4), .MinWaitCycles(3), .MaxWaitCycles(3)) u_b (
        .clk_i(clk), .rst_i(rst), .push_data_i(b_push_data), .push_valid_i(b_push_valid),
        .push_ready_o(b_push_ready), .data_o(b_data), .valid_o(b_valid), .ready_i(b_ready),
        .count_o(b_count), .idle_o(b_idle));

    rand_stream_mst #(.data_t(logic [7:0]), .Depth(4), .MinWaitCycles(1), .MaxWaitCycles(7)) u_c (
        .clk_i(clk), .rst_i(rst), .push_data_i(c_push_data), .push_valid_i(c_push_valid),
        .push_ready_o(c_push_ready), .data_o(c_data), .valid_o(c_valid), .ready_i(c_ready),
        .count_o(c_count), .idle_o(c_idle));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the zero-gap instance: occupancy and order.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_count_vs_sb", 32'(a_count), 32'(qa.size()));
            if (a_valid && a_ready) begin
                if (qa.size() == 0) chk("a_unexpected_beat", 32'(qa.size()), 32'd1);
                else chk("a_order", 32'(a_data), 32'(qa.pop_front()));
            end
            if (a_push_valid && a_push_ready) qa.push_back(a_push_data);
        end
    end

    // Scoreboard plus gap model for the random-gap instance: each rise of valid consumes one draw.
    int          c_gap = 0;
    int          c_pops = 0;
    int          c_exp_w;
    bit          c_drawn = 1'b0;
    bit          c_prev_valid = 1'b0;
    logic [15:0] c_lfsr = 16'hACE1;

    always @(negedge clk) begin
        if (rst) begin
            c_gap        = 0;
            c_drawn      = 1'b0;
            c_prev_valid = 1'b0;
            c_lfsr       = 16'hACE1;
        end else begin
            chk("c_count_vs_sb", 32'(c_count), 32'(qc.size()));
            if (!c_valid) c_gap++;
            if (c_valid && !c_prev_valid) begin
                c_exp_w = 1 + int'(c_lfsr % 16'd7);
                c_lfsr  = (c_lfsr >> 1) ^ (c_lfsr[0] ? 16'hB400 : 16'h0000);
                if (c_drawn) begin
                    chk("c_gap_in_range", 32'((c_gap >= 1) && (c_gap <= 7)), 32'd1);
                    chk("c_gap_exact", 32'(c_gap), 32'(c_exp_w));
                end
                c_drawn = 1'b0;
            end
            if (c_valid && c_ready) begin
                c_pops++;
                if (qc.size() == 0) chk("c_unexpected_beat", 32'(qc.size()), 32'd1);
                else chk("c_order", 32'(c_data), 32'(qc.pop_front()));
                c_drawn = (c_count > 3'd1) || (c_push_valid && c_push_ready);
                c_gap   = 0;
            end
            if (c_push_valid && c_push_ready) qc.push_back(c_push_data);
            c_prev_valid = c_valid;
        end
    end

    int n;
    int gap;
    int pushed;

    initial begin
        rst = 1'b1;
        a_push_data = '0; a_push_valid = 1'b0; a_ready = 1'b0;
        b_push_data = '0; b_push_valid = 1'b0; b_ready = 1'b0;
        c_push_data = '0; c_push_valid = 1'b0; c_ready = 1'b0;
        repeat (3) tick;

        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_push_ready", 32'(a_push_ready), 32'd1);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_idle", 32'(a_idle), 32'd1);
        chk("rst_c_idle", 32'(c_idle), 32'd1);

        // Zero-gap back-to-back stream; first push right after reset release.
        rst = 1'b0;
        a_ready = 1'b1;
        a_push_valid = 1'b1; a_push_data = 8'h01; tick;
        chk("a_first_push_count", 32'(a_count), 32'd1);
        chk("a_latency_valid_low", 32'(a_valid), 32'd0);
        a_push_data = 8'h02; tick;
        chk("a_beat01_valid", 32'(a_valid), 32'd1);
        chk("a_beat01_data", 32'(a_data), 32'h01);
        a_push_data = 8'h03; tick;
        chk("a_beat02_valid", 32'(a_valid), 32'd1);
        chk("a_beat02_data", 32'(a_data), 32'h02);
        a_push_data = 8'h04; tick;
        chk("a_beat03_valid", 32'(a_valid), 32'd1);
        chk("a_beat03_data", 32'(a_data), 32'h03);
        a_push_valid = 1'b0; tick;
        chk("a_beat04_valid", 32'(a_valid), 32'd1);
        chk("a_beat04_data", 32'(a_data), 32'h04);
        tick;
        chk("a_drained_valid", 32'(a_valid), 32'd0);
        chk("a_drained_idle", 32'(a_idle), 32'd1);

        // Backpressure: fill the buffer, hold the head, then release one beat.
        a_ready = 1'b0;
        a_push_valid = 1'b1;
        a_push_data = 8'hA5; tick;
        a_push_data = 8'hB1; tick;
        a_push_data = 8'hC2; tick;
        a_push_data = 8'hD3; tick;
        a_push_valid = 1'b0;
        chk("a_full_push_ready", 32'(a_push_ready), 32'd0);
        chk("a_full_count", 32'(a_count), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("a_hold_valid", 32'(a_valid), 32'd1);
            chk("a_hold_data", 32'(a_data), 32'hA5);
        end
        a_ready = 1'b1; tick;
        chk("a_after_pop_push_ready", 32'(a_push_ready), 32'd1);
        chk("a_after_pop_count", 32'(a_count), 32'd3);
        chk("a_after_pop_data", 32'(a_data), 32'hB1);
        a_ready = 1'b0;
        chk("a_pre_rst_valid", 32'(a_valid), 32'd1);

        // Reset mid-transfer must act immediately and discard the buffered beats.
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(a_valid), 32'd0);
        chk("mid_rst_count", 32'(a_count), 32'd0);
        chk("mid_rst_idle", 32'(a_idle), 32'd1);
        chk("mid_rst_push_ready", 32'(a_push_ready), 32'd1);
        qa.delete();
        tick;
        rst = 1'b0;
        a_ready = 1'b1;
        a_push_valid = 1'b1; a_push_data = 8'h5E; tick;
        a_push_valid = 1'b0;
        chk("post_rst_count", 32'(a_count), 32'd1);
        tick;
        chk("post_rst_valid", 32'(a_valid), 32'd1);
        chk("post_rst_first_data", 32'(a_data), 32'h5E);
        tick;
        chk("post_rst_idle", 32'(a_idle), 32'd1);

        // Fixed 3-cycle gap: latency 1+W from push, then exactly 3 low cycles.
        b_ready = 1'b1;
        b_push_valid = 1'b1; b_push_data = 8'h11; tick;
        b_push_data = 8'h22; tick;
        b_push_valid = 1'b0;
        n = 1;
        while (!b_valid && n < 20) begin
            tick;
            n++;
        end
        chk("b_latency", 32'(n), 32'd4);
        chk("b_first_data", 32'(b_data), 32'h11);
        tick;
        gap = 0;
        while (!b_valid && gap < 20) begin
            tick;
            gap++;
        end
        chk("b_gap", 32'(gap), 32'd3);
        chk("b_second_data", 32'(b_data), 32'h22);
        tick;
        chk("b_idle", 32'(b_idle), 32'd1);

        // Random gaps with random backpressure over 1000 beats.
        pushed = 0;
        for (int cyc = 0; cyc < 40000 && pushed < 1000; cyc++) begin
            c_push_valid = ($urandom_range(3) != 0);
            c_push_data  = 8'($urandom);
            c_ready      = 1'($urandom_range(1));
            if (c_push_valid && c_push_ready) pushed++;
            tick;
        end
        c_push_valid = 1'b0;
        c_ready = 1'b1;
        for (int k = 0; k < 400 && !c_idle; k++) tick;
        tick;
        chk("c_pushed", 32'(pushed), 32'd1000);
        chk("c_popped", 32'(c_pops), 32'd1000);
        chk("c_sb_drained", 32'(qc.size()), 32'd0);
        chk("c_idle", 32'(c_idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
